// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 key schedule sequencer.
package aes_pkg;

  localparam int KEY_W = 128;
  localparam int NR    = 10;

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
  typedef logic [3:0] rk_idx_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input rk_idx_t rc);
    case (rc)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_keygen.sv
// Combinational single-round AES-128 key expansion: previous round key in, next round key out.
module keygeneration
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic [3:0]       rc,
  input  logic             start,
  output logic [KEY_W-1:0] keyout,
  output logic             finished
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, tmp;
  logic [31:0] o0, o1, o2, o3;

  assign {w0, w1, w2, w3} = key;
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign tmp = sub ^ {rcon(rc), 24'h000000};

  assign o0 = w0 ^ tmp;
  assign o1 = w1 ^ o0;
  assign o2 = w2 ^ o1;
  assign o3 = w3 ^ o2;

  assign keyout   = {o0, o1, o2, o3};
  assign finished = start;

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key schedule sequencer: expands one round per clock into an 11-entry round-key file.
module aes_key_schedule_ctrl #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [3:0]       rd_addr,
  output logic [KEY_W-1:0] rd_key
);
  import aes_pkg::*;

  state_t           state_q, state_d;
  rk_idx_t          rc_q, rc_d;
  logic [KEY_W-1:0] key_cap_q, key_cap_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             keys_valid_q, keys_valid_d;
  logic [KEY_W-1:0] rk_q [NR+1];
  logic [KEY_W-1:0] rk_d [NR+1];

  logic [KEY_W-1:0] kg_keyout;
  logic             kg_finished;

  keygeneration u_keygen (
    .key      (rk_q[rc_q]),
    .rc       (rc_q),
    .start    (1'b1),
    .keyout   (kg_keyout),
    .finished (kg_finished)
  );

  always_comb begin
    state_d      = state_q;
    rc_d         = rc_q;
    key_cap_d    = key_cap_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    keys_valid_d = keys_valid_q;
    rk_d         = rk_q;
    case (state_q)
      IDLE: begin
        busy_d = start;
        if (start) begin
          key_cap_d    = key_in;
          keys_valid_d = 1'b0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        busy_d   = 1'b1;
        rk_d[0]  = key_cap_q;
        rc_d     = '0;
        state_d  = EXPAND;
      end
      EXPAND: begin
        busy_d = 1'b1;
        if (kg_finished) rk_d[rc_q + 4'd1] = kg_keyout;
        if (rc_q == rk_idx_t'(NR - 1)) begin
          rc_d    = '0;
          state_d = DONE;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      DONE: begin
        // busy stays high through the done cycle and drops on the following edge
        busy_d       = 1'b1;
        keys_valid_d = 1'b1;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rc_q         <= '0;
      key_cap_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rk_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      rc_q         <= rc_d;
      key_cap_q    <= key_cap_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
      rk_q         <= rk_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rd_key     = (rd_addr <= rk_idx_t'(NR)) ? rk_q[rd_addr] : '0;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Randomized self-checking bench for aes_key_schedule_ctrl against a word-level FIPS-197 model.
module tb_aes_key_schedule_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sb_tab [256];
  logic [7:0]   rcon_tab [11];
  logic [127:0] exp_rk [11];

  aes_key_schedule_ctrl #(.NR(10), .KEY_W(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_addr    (rd_addr),
    .rd_key     (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // polynomial product then reduction modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
               inv[(i + 7) % 8] ^ c[i];
      sb_tab[x] = s;
    end
    rcon_tab[0] = 8'h00;
    rcon_tab[1] = 8'h01;
    for (int i = 2; i < 11; i++) rcon_tab[i] = tb_mul(rcon_tab[i-1], 8'h02);
  endtask

  task automatic build_sched(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
        t = t ^ {rcon_tab[i/4], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at the negedge right after the accepting edge; returns edges until done is seen.
  task automatic wait_done(input bit repulse, output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      if (repulse && (lat == 2 || lat == 11)) begin
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("%s_rk%0d", tag, a), rd_key, (a <= 10) ? exp_rk[a] : 128'h0);
    end
  endtask

  task automatic expand_and_check(input logic [127:0] k, input bit repulse, input string tag);
    int lat;
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    chk({tag, "_busy_rise"}, 128'(busy), 128'd1);
    chk({tag, "_kv_clear"}, 128'(keys_valid), 128'd0);
    wait_done(repulse, lat);
    chk({tag, "_done_lat"}, 128'(lat), 128'd12);
    chk({tag, "_kv_set"}, 128'(keys_valid), 128'd1);
    chk({tag, "_busy_at_done"}, 128'(busy), 128'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk({tag, "_done_pulse"}, 128'(done), 128'd0);
      chk({tag, "_busy_fall"}, 128'(busy), 128'd0);
    end
    build_sched(k);
    read_all(tag);
  endtask

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090a0b0c0d0e0f;

  initial begin
    int lat;
    logic [127:0] k;
    rst_n   = 1'b0;
    start   = 1'b0;
    key_in  = '0;
    rd_addr = '0;
    build_tables();
    #23;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_kv", 128'(keys_valid), 128'd0);
    for (int a = 0; a < 11; a++) exp_rk[a] = '0;
    read_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    expand_and_check(KEY_A1, 1'b0, "a1");
    rd_addr = 4'd1;  #1; chk("a1_fips_rk1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_addr = 4'd10; #1; chk("a1_fips_rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    expand_and_check(128'h0, 1'b0, "zero");
    rd_addr = 4'd1; #1; chk("zero_fips_rk1", rd_key, 128'h62636363626363636263636362636363);
    rd_addr = 4'd0; #1; chk("zero_rk0", rd_key, 128'h0);

    expand_and_check(KEY_A1, 1'b1, "repulse");
    rd_addr = 4'd10; #1; chk("repulse_rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // asynchronous reset in the middle of an expansion
    @(negedge clk);
    start  = 1'b1;
    key_in = KEY_SEQ;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_kv", 128'(keys_valid), 128'd0);
    chk("midrst_done", 128'(done), 128'd0);
    for (int a = 0; a < 11; a++) exp_rk[a] = '0;
    read_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    expand_and_check(KEY_A1, 1'b0, "postrst");

    // back-to-back: second start presented during the done cycle, accepted on the next edge
    @(negedge clk);
    start  = 1'b1;
    key_in = KEY_A1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, lat);
    chk("b2b_first_lat", 128'(lat), 128'd12);
    start  = 1'b1;
    key_in = KEY_SEQ;
    @(negedge clk);
    start  = 1'b0;
    key_in = '0;
    chk("b2b_kv_drop", 128'(keys_valid), 128'd0);
    chk("b2b_busy", 128'(busy), 128'd1);
    chk("b2b_done_low", 128'(done), 128'd0);
    wait_done(1'b0, lat);
    chk("b2b_second_lat", 128'(lat), 128'd12);
    rd_addr = 4'd10; #1; chk("b2b_fips_rk10", rd_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    build_sched(KEY_SEQ);
    read_all("b2b");

    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand_and_check(k, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    for (int n = 0; n < 8; n++) begin
      rd_addr = 4'($urandom_range(11, 15));
      #1;
      chk("oob_read", rd_key, 128'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
